if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode control logic.
- Owns the PC and issues one request at a time on the instruction SRAM-like (req/addr_ok/data_ok) interface.
- Holds the fetched word until decode accepts it, and drives the IF/ID valid bit that qualifies decode's next-PC selects.
- Implements the MIPS branch delay slot, exception redirect/flush and instruction-fetch address-error (AdEL) tagging.

Parameters:
- RESET_PC, 32'hBFC00000, PC of the first fetch after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- next_pc_is_next  in  1  decode select: sequential PC.
- next_pc_is_branch_target  in  1  decode select: conditional-branch target.
- next_pc_is_jal_target  in  1  decode select: j/jal target.
- next_pc_is_jr_target  in  1  decode select: jr/jalr target.
- branch_target  in  32  target used with the branch select.
- jal_target  in  32  target used with the j/jal select.
- jr_target  in  32  target used with the jr/jalr select.
- id_br_fire  in  1  instruction in ID leaves ID this cycle; next_pc_is_* are sampled only when this is high.
- id_allowin  in  1  ID can accept a new instruction this cycle.
- exc_redirect  in  1  exception or eret flush pulse from a later stage.
- exc_pc  in  32  redirect address paired with exc_redirect.
- inst_sram_req  out  1  fetch request.
- inst_sram_addr  out  32  fetch address; equals pc.
- inst_sram_addr_ok  in  1  request accepted this cycle.
- inst_sram_data_ok  in  1  read data valid this cycle.
- inst_sram_rdata  in  32  read data.
- is_IF_ID_valid  out  1  instruction word available to ID.
- if_id_pc  out  32  PC of the offered instruction.
- if_id_inst  out  32  instruction word; 0 when AdEL.
- if_id_exc_adel  out  1  offered instruction has a misaligned PC.

Behaviour:
- FSM states:
  - IDLE: reset state.
  - REQ: inst_sram_req=1.
  - WAIT: request accepted, data outstanding.
  - OUT: word held, is_IF_ID_valid=1.
  - DROP: data still outstanding, but the word will be discarded.
- Reset:
  - state=IDLE, pc=RESET_PC, pend=0.
  - inst_sram_req=0, is_IF_ID_valid=0, if_id_exc_adel=0.
  - if_id_pc=0, if_id_inst=0.
  - IDLE goes to REQ on the next cycle.
- REQ:
  - If pc[1:0]!=0: inst_sram_req stays 0. Go to OUT with if_id_inst=0, if_id_exc_adel=1, if_id_pc=pc.
  - Otherwise hold req until addr_ok=1, then go to WAIT. The address must be stable while req=1.
- WAIT:
  - On data_ok, capture rdata and pc into the output registers and go to OUT.
  - Output is valid the cycle after data_ok.
  - data_ok never arrives in the same cycle as addr_ok.
- OUT:
  - is_IF_ID_valid=1. if_fire = is_IF_ID_valid & id_allowin.
  - On if_fire, go to REQ. pc <= (pend | br_now) ? target : pc+4.
  - pend and br_now are then cleared.
- Branch / delay slot:
  - br_now = id_br_fire & ~next_pc_is_next.
  - target is selected one-hot by the next_pc_is_* lines: branch_target, jal_target or jr_target.
  - If br_now is high without an if_fire in the same cycle, latch pend=1 and the target.
  - The instruction currently being fetched or held is the delay slot. Only the fetch after it uses the target.
  - If br_now and if_fire coincide, the target is applied directly.
- Exception redirect (highest priority, any state):
  - pc <= exc_pc, pend <= 0, is_IF_ID_valid <= 0 next cycle.
  - From OUT or REQ: go to REQ. A REQ already accepted (addr_ok in the same cycle) goes to DROP instead.
  - From WAIT: go to DROP.
  - From DROP: stay in DROP with the new pc.
  - DROP: on data_ok, discard the word and go to REQ with the current pc.
  - When exc_redirect and if_fire coincide, the redirect wins.
- Invariants:
  - pc increment wraps modulo 2^32.
  - Never more than one outstanding request.
  - No duplicate or lost instruction handed to ID.
- Reset asserted mid-transaction: return to IDLE immediately. Any late data_ok seen in IDLE or REQ is ignored.

Test Plan:
- Reset, then zero-latency memory (addr_ok same cycle as req, data_ok next cycle), id_allowin=1 → fetch addresses BFC00000, BFC00004, BFC00008; one instruction delivered every 3 cycles; is_IF_ID_valid low during reset.
- Word at BFC00004 held in OUT with id_allowin=0 for 5 cycles → if_id_pc/if_id_inst stable, no new req; after id_allowin=1, the next fetch is BFC00008.
- Branch at 80000100 with id_br_fire, next_pc_is_branch_target=1, branch_target=80000200, delay slot still in WAIT → 80000104 delivered, then fetch 80000200; repeat with br_fire in the same cycle as if_fire → same order.
- exc_redirect, exc_pc=BFC00380 while in WAIT, data_ok 2 cycles later → that word never reaches ID; next req address BFC00380.
- jr with jr_target=80000002 → delay slot delivered; next output has if_id_exc_adel=1, if_id_inst=0, if_id_pc=80000002; no req issued for it.
- Reset asserted while in WAIT; stray data_ok in the first cycle after reset → ignored; first fetch at BFC00000.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs one req/addr_ok/data_ok fetch at a time,
// holds the word for decode, and handles delay slots, exception redirects and AdEL tagging.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000,
   localparam int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            next_pc_is_next,
   input  logic            next_pc_is_branch_target,
   input  logic            next_pc_is_jal_target,
   input  logic            next_pc_is_jr_target,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jal_target,
   input  logic [XLEN-1:0] jr_target,
   input  logic            id_br_fire,
   input  logic            id_allowin,
   input  logic            exc_redirect,
   input  logic [XLEN-1:0] exc_pc,
   output logic            inst_sram_req,
   output logic [XLEN-1:0] inst_sram_addr,
   input  logic            inst_sram_addr_ok,
   input  logic            inst_sram_data_ok,
   input  logic [XLEN-1:0] inst_sram_rdata,
   output logic            is_IF_ID_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_inst,
   output logic            if_id_exc_adel
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_OUT  = 3'd3,
      S_DROP = 3'd4
   } state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic            pend, pend_nxt;
   logic [XLEN-1:0] pend_target, pend_target_nxt;
   logic            req_nxt;
   logic            valid_nxt;
   logic [XLEN-1:0] out_pc_nxt, out_inst_nxt;
   logic            out_adel_nxt;

   logic            if_fire;
   logic            br_now;
   logic            accepted;
   logic            misaligned;
   logic [XLEN-1:0] sel_target;

   assign if_fire    = is_IF_ID_valid & id_allowin;
   assign br_now     = id_br_fire & ~next_pc_is_next;
   assign accepted   = inst_sram_req & inst_sram_addr_ok;
   assign misaligned = (pc[1:0] != 2'b00);
   assign inst_sram_addr = pc;

   // Redirect target is a one-hot AND-OR of decode's select lines.
   assign sel_target = ({XLEN{next_pc_is_branch_target}} & branch_target)
                     | ({XLEN{next_pc_is_jal_target}}    & jal_target)
                     | ({XLEN{next_pc_is_jr_target}}     & jr_target);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; redirect outranks everything, and an outstanding read is always drained.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: state_nxt = S_REQ;
         S_REQ: begin
            if (exc_redirect) begin
               state_nxt = accepted ? S_DROP : S_REQ;
            end else if (misaligned) begin
               state_nxt = S_OUT;
            end else if (accepted) begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (exc_redirect) begin
               state_nxt = inst_sram_data_ok ? S_REQ : S_DROP;
            end else if (inst_sram_data_ok) begin
               state_nxt = S_OUT;
            end
         end
         S_OUT: begin
            if (exc_redirect || if_fire) begin
               state_nxt = S_REQ;
            end
         end
         S_DROP: begin
            if (inst_sram_data_ok) begin
               state_nxt = S_REQ;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output / datapath next values: PC selection, delay-slot pending target, IF/ID capture.
   always_comb begin
      pc_nxt          = pc;
      pend_nxt        = pend;
      pend_target_nxt = pend_target;
      out_pc_nxt      = if_id_pc;
      out_inst_nxt    = if_id_inst;
      out_adel_nxt    = if_id_exc_adel;

      if (exc_redirect) begin
         pc_nxt   = exc_pc;
         pend_nxt = 1'b0;
      end else begin
         if ((state == S_OUT) && if_fire) begin
            if (br_now) begin
               pc_nxt = sel_target;
            end else if (pend) begin
               pc_nxt = pend_target;
            end else begin
               pc_nxt = pc + XLEN'(4);
            end
            pend_nxt = 1'b0;
         end else if (br_now) begin
            // The word in flight is the delay slot; the target waits for it to leave.
            pend_nxt        = 1'b1;
            pend_target_nxt = sel_target;
         end

         if ((state == S_WAIT) && inst_sram_data_ok) begin
            out_pc_nxt   = pc;
            out_inst_nxt = inst_sram_rdata;
            out_adel_nxt = 1'b0;
         end else if ((state == S_REQ) && misaligned) begin
            out_pc_nxt   = pc;
            out_inst_nxt = '0;
            out_adel_nxt = 1'b1;
         end
      end

      req_nxt   = (state_nxt == S_REQ) && (pc_nxt[1:0] == 2'b00);
      valid_nxt = (state_nxt == S_OUT);
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc             <= RESET_PC;
         pend           <= 1'b0;
         pend_target    <= '0;
         inst_sram_req  <= 1'b0;
         is_IF_ID_valid <= 1'b0;
         if_id_pc       <= '0;
         if_id_inst     <= '0;
         if_id_exc_adel <= 1'b0;
      end else begin
         pc             <= pc_nxt;
         pend           <= pend_nxt;
         pend_target    <= pend_target_nxt;
         inst_sram_req  <= req_nxt;
         is_IF_ID_valid <= valid_nxt;
         if_id_pc       <= out_pc_nxt;
         if_id_inst     <= out_inst_nxt;
         if_id_exc_adel <= out_adel_nxt;
      end
   end

endmodule
